// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor. It processes DIGIT bits per clock through a small
// ripple of full adders and presents a registered result after WIDTH/DIGIT cycles.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carryin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow
);

    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (DIGIT < 1 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  part_q, part_d;
    logic              carry_q, carry_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic [DIGIT+1:0]       digit_s;
    logic [DIGIT-1:0]       dsum_s;
    logic                   dcout_s;
    logic                   dcmsb_s;
    logic [WIDTH+DIGIT-1:0] part_ext_s;
    logic [WIDTH-1:0]       part_next_s;
    logic                   accept_s;
    logic                   last_s;

    // Ripple of DIGIT full adders; returns {carry into top cell, carry out, sum bits}.
    function automatic logic [DIGIT+1:0] digit_add(input logic [DIGIT-1:0] x,
                                                   input logic [DIGIT-1:0] y,
                                                   input logic             cin);
        logic [DIGIT:0]   c;
        logic [DIGIT-1:0] s;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
        end
        return {c[DIGIT-1], c[DIGIT], s};
    endfunction

    assign digit_s     = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
    assign dsum_s      = digit_s[DIGIT-1:0];
    assign dcout_s     = digit_s[DIGIT];
    assign dcmsb_s     = digit_s[DIGIT+1];
    assign part_ext_s  = {dsum_s, part_q};
    assign part_next_s = part_ext_s[WIDTH+DIGIT-1:DIGIT];
    assign accept_s    = start && (state_q != RUN);
    assign last_s      = (state_q == RUN) && (cnt_q == CW'(N - 1));

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start  ? RUN  : IDLE;
            RUN:     state_d = last_s ? DONE : RUN;
            DONE:    state_d = start  ? RUN  : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch on accept, shift one digit per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        part_d  = part_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept_s) begin
            a_d     = a;
            b_d     = b ^ {WIDTH{sub}};
            carry_d = carryin ^ sub;
            part_d  = '0;
            cnt_d   = '0;
        end else if (state_q == RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            part_d  = part_next_s;
            carry_d = dcout_s;
            cnt_d   = cnt_q + CW'(1);
            if (last_s) begin
                sum_d  = part_next_s;
                cout_d = dcout_s;
                ovf_d  = dcmsb_s ^ dcout_s;
            end else begin
                sum_d  = sum_q;
            end
        end else begin
            cnt_d   = cnt_q;
        end
    end

    // Status decode from the state register.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    assign sum      = sum_q;
    assign carryout = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: four instances (DIGIT 1,2,4,8) share stimulus and are checked
// against an integer add/subtract model for result, status timing and reset behaviour.
module tb_serial_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       sub;
    logic       carryin;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] carryout;
    logic [3:0] overflow;
    logic [7:0] sum [4];

    int n_checks = 0;
    int n_fail   = 0;

    serial_addsub #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .carryin(carryin),
        .busy(busy[0]), .done(done[0]), .sum(sum[0]), .carryout(carryout[0]), .overflow(overflow[0]));
    serial_addsub #(.WIDTH(8), .DIGIT(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .carryin(carryin),
        .busy(busy[1]), .done(done[1]), .sum(sum[1]), .carryout(carryout[1]), .overflow(overflow[1]));
    serial_addsub #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .carryin(carryin),
        .busy(busy[2]), .done(done[2]), .sum(sum[2]), .carryout(carryout[2]), .overflow(overflow[2]));
    serial_addsub #(.WIDTH(8), .DIGIT(8)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .carryin(carryin),
        .busy(busy[3]), .done(done[3]), .sum(sum[3]), .carryout(carryout[3]), .overflow(overflow[3]));

    // Reference: {overflow, carryout, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                         input logic mcin, input logic msub);
        int   ur;
        int   sr;
        logic cout;
        logic ovf;
        if (!msub) begin
            ur   = int'(ma) + int'(mb) + int'(mcin);
            sr   = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
            cout = (ur > 255);
        end else begin
            ur   = int'(ma) - int'(mb) - int'(mcin);
            sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mcin);
            cout = (ur >= 0);
        end
        ovf = (sr > 127) || (sr < -128);
        return {ovf, cout, ur[7:0]};
    endfunction

    task automatic scramble();
        a       = 8'($urandom);
        b       = 8'($urandom);
        carryin = 1'($urandom);
        sub     = 1'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        scramble();
        #2;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || sum[i] !== 8'h00 ||
                carryout[i] !== 1'b0 || overflow[i] !== 1'b0)
                $display("FAIL reset_state inst%0d: busy=%b done=%b sum=%h co=%b ov=%b, required all 0",
                         i, busy[i], done[i], sum[i], carryout[i], overflow[i]);
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || sum[i] !== 8'h00 ||
                carryout[i] !== 1'b0 || overflow[i] !== 1'b0)
                n_fail++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One operation on all four instances; status checked every cycle, result from done on.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib,
                          input logic icin, input logic isub, input string tag);
        logic [9:0] exp;
        int         n;
        exp = model(ia, ib, icin, isub);
        @(posedge clk); #1;
        a = ia; b = ib; carryin = icin; sub = isub; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            scramble();
            for (int i = 0; i < 4; i++) begin
                n = 8 >> i;
                n_checks++;
                if (busy[i] !== (k < n) || done[i] !== (k == n)) begin
                    n_fail++;
                    $display("FAIL %s_timing inst%0d cycle%0d: busy=%b done=%b, required busy=%b done=%b",
                             tag, i, k, busy[i], done[i], (k < n), (k == n));
                end
                if (k >= n) begin
                    n_checks++;
                    if ({overflow[i], carryout[i], sum[i]} !== exp) begin
                        n_fail++;
                        $display("FAIL %s_result inst%0d cycle%0d: ov=%b co=%b sum=%h, required ov=%b co=%b sum=%h",
                                 tag, i, k, overflow[i], carryout[i], sum[i], exp[9], exp[8], exp[7:0]);
                    end
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, "add_0f_01");
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, "add_7f_01");
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0, "add_ff_ff_c");
    endtask

    task automatic test_sub();
        run_op(8'h05, 8'h07, 1'b0, 1'b1, "sub_05_07");
        run_op(8'h80, 8'h01, 1'b0, 1'b1, "sub_80_01");
        run_op(8'h00, 8'h00, 1'b1, 1'b1, "sub_00_00_b");
    endtask

    // DIGIT=4 instance: chained starts on the done cycle, spurious start and operand noise in RUN.
    task automatic test_back_to_back();
        logic [7:0] oa [4];
        logic [7:0] ob [4];
        logic       oc [4];
        logic       os [4];
        logic [9:0] exp;
        logic [9:0] prev;
        for (int j = 0; j < 4; j++) begin
            oa[j] = 8'($urandom); ob[j] = 8'($urandom);
            oc[j] = 1'($urandom); os[j] = 1'($urandom);
        end
        prev = 10'd0;
        @(posedge clk); #1;
        a = oa[0]; b = ob[0]; carryin = oc[0]; sub = os[0]; start = 1'b1;
        for (int j = 0; j < 4; j++) begin
            exp = model(oa[j], ob[j], oc[j], os[j]);
            @(posedge clk); #1;
            n_checks++;
            if (busy[2] !== 1'b1 || done[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_accept op%0d: busy=%b done=%b, required busy=1 done=0", j, busy[2], done[2]);
            end
            if (j > 0) begin
                n_checks++;
                if ({overflow[2], carryout[2], sum[2]} !== prev) begin
                    n_fail++;
                    $display("FAIL b2b_hold op%0d: got %h, required %h", j,
                             {overflow[2], carryout[2], sum[2]}, prev);
                end
            end
            scramble();
            start = 1'b1;
            @(posedge clk); #1;
            n_checks++;
            if (busy[2] !== 1'b1 || done[2] !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_run op%0d: busy=%b done=%b, required busy=1 done=0", j, busy[2], done[2]);
            end
            scramble();
            start = 1'b0;
            @(posedge clk); #1;
            n_checks++;
            if (busy[2] !== 1'b0 || done[2] !== 1'b1 || {overflow[2], carryout[2], sum[2]} !== exp) begin
                n_fail++;
                $display("FAIL b2b_done op%0d: busy=%b done=%b res=%h, required busy=0 done=1 res=%h",
                         j, busy[2], done[2], {overflow[2], carryout[2], sum[2]}, exp);
            end
            prev = exp;
            if (j < 3) begin
                a = oa[j+1]; b = ob[j+1]; carryin = oc[j+1]; sub = os[j+1]; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        a = 8'h3C; b = 8'h5A; carryin = 1'b1; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (busy[i] !== 1'b0 || done[i] !== 1'b0 || sum[i] !== 8'h00 ||
                carryout[i] !== 1'b0 || overflow[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_clear inst%0d: busy=%b done=%b sum=%h co=%b ov=%b, required all 0",
                         i, busy[i], done[i], sum[i], carryout[i], overflow[i]);
            end
        end
        #4 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL midrst_idle inst%0d cycle%0d: busy=%b done=%b, required 0 0",
                             i, k, busy[i], done[i]);
                end
            end
        end
        run_op(8'hA5, 8'h5A, 1'b0, 1'b1, "after_midrst");
    endtask

    task automatic test_random();
        for (int t = 0; t < 1500; t++)
            run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), "random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
